mimo_gearbox: RTL
=================

Name: mimo_gearbox

Overview:
Parametrised element-granular multi-in/multi-out width converter.
- Each cycle it accepts 0..IN_ELEMS elements and delivers 0..OUT_ELEMS elements.
- Storage is a circular buffer of CAP_ELEMS elements.
- Supports partial enqueue/dequeue, concurrent enqueue and dequeue in one cycle, and either width ratio (narrow-to-wide or wide-to-narrow).
- Sits between stream producers and consumers of differing beat widths, e.g. 32-bit DMA words into 128-bit compute vectors.

Parameters:
ELEM_WIDTH, 8, bits per element
IN_ELEMS, 4, max elements per enqueue beat
OUT_ELEMS, 16, max elements presented/removed per dequeue beat
CAP_ELEMS, 24, buffer capacity in elements; must be >= IN_ELEMS + OUT_ELEMS, need not be a power of two

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  reset; synchronous, active-high
in$enq__ENA  input  1  enqueue strobe
in$enq$v  input  IN_ELEMS*ELEM_WIDTH  enqueue data; element i at bits [i*ELEM_WIDTH +: ELEM_WIDTH]
in$enq$count  input  $clog2(IN_ELEMS+1)  number of valid low elements in in$enq$v
in$enq__RDY  output  1  enqueue permitted
out$deq__ENA  input  1  dequeue strobe
out$deq$count  input  $clog2(OUT_ELEMS+1)  elements to remove
out$deq__RDY  output  1  dequeue permitted
out$first  output  OUT_ELEMS*ELEM_WIDTH  oldest elements; oldest in the LSBs
out$first$count  output  $clog2(OUT_ELEMS+1)  valid elements in out$first
out$first__RDY  output  1  out$first valid
occupancy  output  $clog2(CAP_ELEMS+1)  elements held

Behaviour:
State and derived signals
- State: head pointer (0..CAP_ELEMS-1), occupancy count (0..CAP_ELEMS), storage array.
- Tail = (head + occupancy) mod CAP_ELEMS. All pointer arithmetic wraps modulo CAP_ELEMS with explicit compare-and-subtract; no power-of-two masking.
- in$enq__RDY = (CAP_ELEMS - occupancy) >= IN_ELEMS. Computed from registered state only; independent of out$deq__ENA.
- out$deq__RDY = out$first__RDY = occupancy != 0.
- out$first$count = min(occupancy, OUT_ELEMS).
- out$first element j = storage[(head + j) mod CAP_ELEMS] for j < out$first$count. Lanes at or above out$first$count are driven zero.

Enqueue and dequeue
- Enqueue fires when in$enq__ENA & in$enq__RDY. Elements 0..count-1 are written at tail..tail+count-1 (wrapping). count=0 is a legal no-op.
- in$enq$count > IN_ELEMS is clamped to IN_ELEMS.
- in$enq__ENA while !RDY: ignored, no state change.
- Dequeue fires when out$deq__ENA & out$deq__RDY. Removes n = min(out$deq$count, out$first$count) elements; head advances by n.
- out$deq__ENA while !RDY: ignored.

Timing
- Latency: enqueued data is visible on out$first the cycle after the enqueue edge. There is no combinational bypass.
- Simultaneous enqueue and dequeue in one cycle: occupancy_next = occupancy + enq_n - deq_n.
- The dequeue only reads elements already present, so enqueue and dequeue never touch the same slot. Legal because CAP_ELEMS >= IN_ELEMS + OUT_ELEMS.

Reset
- RST high at a clock edge sets head=0 and occupancy=0, clearing all contents, including in the middle of a transfer.
- Storage contents are not cleared, but are unobservable because outputs are masked.
- Output values during reset: in$enq__RDY=1, out$deq__RDY=0, out$first__RDY=0, out$first$count=0, out$first=0, occupancy=0.
- RST has priority over any ENA in the same cycle.

Boundaries
- Full: occupancy > CAP_ELEMS - IN_ELEMS drops in$enq__RDY, even when fewer than IN_ELEMS elements are offered.
- Empty: out$first is all zero.

Optional Feature:
MIMO_GEARBOX_STATS_EN
- Defined: adds the following outputs.
  - stat$hwm [$clog2(CAP_ELEMS+1)]: maximum occupancy since reset.
  - stat$ovf (1 bit, sticky): set when in$enq__ENA & !in$enq__RDY.
  - stat$unf (1 bit, sticky): set when out$deq__ENA and (!out$deq__RDY or out$deq$count > out$first$count).
  - All three are cleared only by RST. The flags are set the cycle after the offending strobe.
- Undefined: these ports and their logic are absent. Clamping/ignore behaviour is unchanged.

Test Plan:
1. Reset: RST=1 for 2 cycles, then 0 -> in$enq__RDY=1, out$first__RDY=0, out$first$count=0, out$first=0, occupancy=0.
2. Narrow-to-wide: four full enqueues of 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> next cycle out$first$count=16, out$first=0x0F0E0D0C0B0A09080706050403020100. deq count=16 -> occupancy=0.
3. Partial: enq count=3 with v=0x00AABBCC -> out$first$count=3, out$first=0x...00AABBCC with upper lanes zero. deq count=2 -> out$first=0xAA, count=1. deq count=5 -> removes 1 only, occupancy=0.
4. Full: six 4-element enqueues -> occupancy 24. After the 5th (occupancy 20), RDY is still 1; after the 6th, RDY=0. A 7th ENA is ignored, occupancy stays 24, and stat$ovf=1 when STATS_EN is defined. stat$hwm=24.
5. Concurrency/wrap: at occupancy 20 with head=8, enq 4 and deq 16 in the same cycle -> occupancy 8, head=0. Element ordering across the wrap matches the enqueue order.
6. Reset mid-operation: at occupancy 12, RST=1 concurrently with enq ENA -> occupancy 0, enq discarded, stat flags cleared. A subsequent enq of 0x44332211 gives out$first=0x44332211.

Source files
------------

// File: rtl/mimo_gearbox.sv
// Element-granular multi-in/multi-out width converter over a circular buffer.
// Optional MIMO_GEARBOX_STATS_EN adds high-water mark and sticky ovf/unf flags.
module mimo_gearbox #(
  parameter int ELEM_WIDTH = 8,
  parameter int IN_ELEMS   = 4,
  parameter int OUT_ELEMS  = 16,
  parameter int CAP_ELEMS  = 24
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                in_enq__ENA,
  input  logic [IN_ELEMS*ELEM_WIDTH-1:0]      in_enq_v,
  input  logic [$clog2(IN_ELEMS+1)-1:0]       in_enq_count,
  output logic                                in_enq__RDY,
  input  logic                                out_deq__ENA,
  input  logic [$clog2(OUT_ELEMS+1)-1:0]      out_deq_count,
  output logic                                out_deq__RDY,
  output logic [OUT_ELEMS*ELEM_WIDTH-1:0]     out_first,
  output logic [$clog2(OUT_ELEMS+1)-1:0]      out_first_count,
  output logic                                out_first__RDY,
  output logic [$clog2(CAP_ELEMS+1)-1:0]      occupancy
`ifdef MIMO_GEARBOX_STATS_EN
  ,
  output logic [$clog2(CAP_ELEMS+1)-1:0]      stat_hwm,
  output logic                                stat_ovf,
  output logic                                stat_unf
`endif
);

  localparam int EW = ELEM_WIDTH;
  localparam int PW = $clog2(CAP_ELEMS);
  localparam int SW = PW + 1;
  localparam int OW = $clog2(CAP_ELEMS + 1);
  localparam int IC = $clog2(IN_ELEMS + 1);
  localparam int OC = $clog2(OUT_ELEMS + 1);

  function automatic logic [PW-1:0] wrap(input logic [SW-1:0] s);
    if (s >= SW'(CAP_ELEMS))
      return PW'(s - SW'(CAP_ELEMS));
    return PW'(s);
  endfunction

  logic [PW-1:0] head;
  logic [OW-1:0] occ;
  logic [EW-1:0] mem [CAP_ELEMS];

  logic          enq_rdy;
  logic          deq_rdy;
  logic          enq_fire;
  logic          deq_fire;
  logic [IC-1:0] enq_n;
  logic [OC-1:0] first_n;
  logic [OC-1:0] deq_n;
  logic [PW-1:0] tail;
  logic [OW-1:0] occ_next;
  logic [OUT_ELEMS*EW-1:0] first;

  assign enq_rdy  = occ <= OW'(CAP_ELEMS - IN_ELEMS);
  assign deq_rdy  = occ != '0;
  assign enq_fire = in_enq__ENA & enq_rdy;
  assign deq_fire = out_deq__ENA & deq_rdy;

  assign enq_n = (in_enq_count > IC'(IN_ELEMS))
               ? IC'(IN_ELEMS) : in_enq_count;
  assign first_n = (occ >= OW'(OUT_ELEMS))
                 ? OC'(OUT_ELEMS) : OC'(occ);
  assign deq_n = (out_deq_count < first_n)
               ? out_deq_count : first_n;

  assign tail = wrap(SW'(head) + SW'(occ));
  assign occ_next = occ
                  + (enq_fire ? OW'(enq_n) : '0)
                  - (deq_fire ? OW'(deq_n) : '0);

  always_comb begin
    first = '0;
    for (int j = 0; j < OUT_ELEMS; j++) begin
      if (OC'(j) < first_n)
        first[j*EW +: EW] = mem[wrap(SW'(head) + SW'(j))];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head <= '0;
      occ  <= '0;
    end else begin
      if (deq_fire)
        head <= wrap(SW'(head) + SW'(deq_n));
      occ <= occ_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && enq_fire) begin
      for (int i = 0; i < IN_ELEMS; i++) begin
        if (IC'(i) < enq_n)
          mem[wrap(SW'(tail) + SW'(i))] <= in_enq_v[i*EW +: EW];
      end
    end
  end

  assign in_enq__RDY     = enq_rdy;
  assign out_deq__RDY    = deq_rdy;
  assign out_first__RDY  = deq_rdy;
  assign out_first_count = first_n;
  assign out_first       = first;
  assign occupancy       = occ;

`ifdef MIMO_GEARBOX_STATS_EN
  logic [OW-1:0] hwm;
  logic          ovf;
  logic          unf;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hwm <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (occ_next > hwm)
        hwm <= occ_next;
      if (in_enq__ENA && !enq_rdy)
        ovf <= 1'b1;
      if (out_deq__ENA && (!deq_rdy || out_deq_count > first_n))
        unf <= 1'b1;
    end
  end

  assign stat_hwm = hwm;
  assign stat_ovf = ovf;
  assign stat_unf = unf;
`endif

endmodule
